// File: rtl/itype_pkg.sv
// Shared constants and types for the I-type issue unit.
// Opcodes, sequencer states and exception cause codes.
package itype_pkg;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_ILL  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/itype_regfile.sv
// 32x32 register file: two async read ports, one sync write port.
// r0 reads as zero on every port.
module itype_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : mem_q[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/itype_issue_unit.sv
// Non-pipelined IDLE/EXEC/WB sequencer feeding an external I-type ALU,
// with writeback into a local register file and a saturating retire counter.
module itype_issue_unit
    import itype_pkg::*;
#(
    parameter int RETIRE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    output logic [31:0]             alu_srca,
    output logic [31:0]             alu_srcb,
    output logic [3:0]              alu_af,
    output logic                    alu_i,
    input  logic [31:0]             alu_res,
    input  logic                    alu_zero,
    input  logic                    alu_neg,
    input  logic                    alu_ovf,
    output logic                    retire_valid,
    output logic [4:0]              retire_rt,
    output logic [31:0]             retire_result,
    output logic                    retire_zero,
    output logic                    retire_neg,
    output logic                    exc_valid,
    output logic [1:0]              exc_cause,
    output logic [RETIRE_CNT_W-1:0] retire_count,
    input  logic [4:0]              dbg_raddr,
    output logic [31:0]             dbg_rdata
);

    state_t state_q, state_d;
    logic [31:0] srca_q, srca_d;
    logic [31:0] srcb_q, srcb_d;
    logic [3:0]  af_q, af_d;
    logic [5:0]  opc_q, opc_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rrt_q, rrt_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;
    logic [RETIRE_CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] rs_data;
    logic [31:0] dbg_data;
    logic        legal;
    logic        in_wb;
    logic        fire;

    itype_regfile u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (retire_valid),
        .waddr   (rrt_q),
        .wdata   (res_q),
        .raddr_a (in_instr[25:21]),
        .rdata_a (rs_data),
        .raddr_b (dbg_raddr),
        .rdata_b (dbg_data)
    );

    assign legal = (opc_q[5:3] == 3'b001);
    assign in_wb = (state_q == S_WB) && !reset;
    assign fire  = in_valid && in_ready;

    assign in_ready      = (state_q == S_IDLE) && !reset;
    assign alu_srca      = srca_q;
    assign alu_srcb      = srcb_q;
    assign alu_af        = af_q;
    assign alu_i         = 1'b1;
    assign retire_rt     = rrt_q;
    assign retire_result = res_q;
    assign retire_zero   = zero_q;
    assign retire_neg    = neg_q;
    assign retire_count  = cnt_q;
    assign dbg_rdata     = reset ? '0 : dbg_data;

    // Illegal opcode outranks overflow; only a clean WB retires.
    assign retire_valid = in_wb && legal && !ovf_q;
    assign exc_valid    = in_wb && (!legal || ovf_q);

    always_comb begin
        exc_cause = EXC_NONE;
        if (in_wb) begin
            if (!legal) begin
                exc_cause = EXC_ILL;
            end else if (ovf_q) begin
                exc_cause = EXC_OVF;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        af_d    = af_q;
        opc_d   = opc_q;
        rt_d    = rt_q;
        rrt_d   = rrt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    srca_d  = rs_data;
                    srcb_d  = {16'b0, in_instr[15:0]};
                    af_d    = {1'b0, in_instr[28:26]};
                    opc_d   = in_instr[31:26];
                    rt_d    = in_instr[20:16];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_res;
                zero_d  = alu_zero;
                neg_d   = alu_neg;
                rrt_d   = rt_q;
                ovf_d   = alu_ovf && (opc_q == OP_ADDI);
                state_d = S_WB;
            end
            S_WB: begin
                if (retire_valid && cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            srca_q  <= '0;
            srcb_q  <= '0;
            af_q    <= '0;
            opc_q   <= '0;
            rt_q    <= '0;
            rrt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            af_q    <= af_d;
            opc_q   <= opc_d;
            rt_q    <= rt_d;
            rrt_q   <= rrt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_itype_issue_unit.sv
// Directed bench for itype_issue_unit with a small behavioural ALU
// whose overflow flag is driven by the stimulus.
module tb_itype_issue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_af;
    logic        alu_i;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_ovf;
    logic        retire_valid;
    logic [4:0]  retire_rt;
    logic [31:0] retire_result;
    logic        retire_zero;
    logic        retire_neg;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [15:0] retire_count;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    logic force_ovf;
    int   total = 0;
    int   bad = 0;

    logic        o_rv, o_ev, o_zero;
    logic [1:0]  o_cause;
    logic [4:0]  o_rt;
    logic [31:0] o_res, o_sa, o_sb;
    logic [3:0]  o_af;

    itype_issue_unit #(.RETIRE_CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .alu_srca      (alu_srca),
        .alu_srcb      (alu_srcb),
        .alu_af        (alu_af),
        .alu_i         (alu_i),
        .alu_res       (alu_res),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .alu_ovf       (alu_ovf),
        .retire_valid  (retire_valid),
        .retire_rt     (retire_rt),
        .retire_result (retire_result),
        .retire_zero   (retire_zero),
        .retire_neg    (retire_neg),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .retire_count  (retire_count),
        .dbg_raddr     (dbg_raddr),
        .dbg_rdata     (dbg_rdata)
    );

    always #5 clk = ~clk;

    // External ALU stand-in; sign-extends the immediate itself.
    always_comb begin
        alu_res = alu_srca + {{16{alu_srcb[15]}}, alu_srcb[15:0]};
        case (alu_af)
            4'd4:    alu_res = alu_srca & alu_srcb;
            4'd5:    alu_res = alu_srca | alu_srcb;
            4'd6:    alu_res = alu_srca ^ alu_srcb;
            4'd7:    alu_res = {alu_srcb[15:0], 16'h0};
            default: ;
        endcase
    end
    assign alu_zero = (alu_res == 32'd0);
    assign alu_neg  = alu_res[31];
    assign alu_ovf  = force_ovf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic dbg(input logic [4:0] a, input logic [31:0] exp,
                       input string tag);
        dbg_raddr = a;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    task automatic issue(input logic [31:0] instr, input logic ovf);
        @(negedge clk);
        in_instr  = instr;
        in_valid  = 1'b1;
        force_ovf = ovf;
        chk("rdy_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 32'hFFFF_FFFF;
        chk("rdy_exec", in_ready, 0);
        o_sa = alu_srca;
        o_sb = alu_srcb;
        o_af = alu_af;
        @(posedge clk);
        #1;
        force_ovf = 1'b0;
        chk("rdy_wb", in_ready, 0);
        o_rv    = retire_valid;
        o_ev    = exc_valid;
        o_cause = exc_cause;
        o_rt    = retire_rt;
        o_res   = retire_result;
        o_zero  = retire_zero;
        @(posedge clk);
        #1;
        chk("pulse_end", {30'd0, retire_valid, exc_valid}, 0);
        chk("rdy_back", in_ready, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        force_ovf = 1'b0;
        dbg_raddr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", in_ready, 0);
        chk("rst_srca", alu_srca, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rdy", in_ready, 1);
        chk("post_cnt", retire_count, 0);
        chk("post_exc", {exc_valid, exc_cause}, 0);
        chk("alu_i", alu_i, 1);
        for (int i = 0; i < 32; i++) begin
            dbg(i[4:0], 32'd0, "rf_zero");
        end

        issue(32'h2001_0005, 1'b0);
        chk("i1_rv", o_rv, 1);
        chk("i1_ev", o_ev, 0);
        chk("i1_rt", o_rt, 1);
        chk("i1_res", o_res, 32'h5);
        chk("i1_zero", o_zero, 0);
        dbg(5'd1, 32'h5, "i1_r1");

        issue(32'h2022_FFFF, 1'b0);
        chk("i2_sa", o_sa, 32'h5);
        chk("i2_sb", o_sb, 32'h0000_FFFF);
        chk("i2_af", o_af, 0);
        chk("i2_rv", o_rv, 1);
        chk("i2_rt", o_rt, 2);
        chk("i2_res", o_res, 32'h4);
        chk("i2_hold", retire_result, 32'h4);
        dbg(5'd2, 32'h4, "i2_r2");
        chk("i2_cnt", retire_count, 2);

        issue(32'h2023_0001, 1'b1);
        chk("ovf_rv", o_rv, 0);
        chk("ovf_ev", o_ev, 1);
        chk("ovf_cause", o_cause, 2'b01);
        dbg(5'd3, 32'h0, "ovf_r3");
        chk("ovf_cnt", retire_count, 2);

        issue(32'h2423_0001, 1'b1);
        chk("addiu_rv", o_rv, 1);
        chk("addiu_ev", o_ev, 0);
        chk("addiu_res", o_res, 32'h6);
        dbg(5'd3, 32'h6, "addiu_r3");
        chk("addiu_cnt", retire_count, 3);

        issue(32'h2000_0007, 1'b0);
        chk("r0_rv", o_rv, 1);
        chk("r0_rt", o_rt, 0);
        chk("r0_res", o_res, 32'h7);
        dbg(5'd0, 32'h0, "r0_zero");
        chk("r0_cnt", retire_count, 4);

        issue(32'h3424_0F0F, 1'b0);
        chk("ori_af", o_af, 5);
        chk("ori_res", o_res, 32'h0000_0F0F);
        dbg(5'd4, 32'h0000_0F0F, "ori_r4");
        chk("ori_cnt", retire_count, 5);

        issue(32'h0000_0020, 1'b0);
        chk("ill_rv", o_rv, 0);
        chk("ill_ev", o_ev, 1);
        chk("ill_cause", o_cause, 2'b10);
        dbg(5'd0, 32'h0, "ill_r0");
        chk("ill_cnt", retire_count, 5);

        @(negedge clk);
        in_instr = 32'h3C05_1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lui_exec", in_ready, 0);
        chk("lui_af", alu_af, 7);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pulse", {30'd0, retire_valid, exc_valid}, 0);
        chk("rst_exc", exc_cause, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_rdy2", in_ready, 1);
        chk("rst_pulse2", {30'd0, retire_valid, exc_valid}, 0);
        chk("rst_cnt", retire_count, 0);
        chk("rst_res", retire_result, 0);
        dbg(5'd5, 32'h0, "rst_r5");
        dbg(5'd1, 32'h0, "rst_r1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
